// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and a
// counter-width helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/operand/result bundle between the CPU control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift a dividend bit into the remainder
// and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem, dividend_bit};
  // The extra top bit of diff acts as the borrow: set means divisor did not fit.
  assign diff     = shifted - {2'b00, divisor};
  assign q_bit    = ~diff[WIDTH+1];
  assign rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply and restoring divide feeding HI/LO.
// Operates on magnitudes one bit per cycle, then fixes signs in a single step.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int              CW   = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mdu_state_e         state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  mdu_op_e            op_reg, op_next;
  logic               sign_a_reg, sign_a_next;
  logic               sign_b_reg, sign_b_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH:0]     rem_reg, rem_next;
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;

  logic               in_div, in_sign_a, in_sign_b, is_div, neg;
  logic [WIDTH-1:0]   in_abs_a, in_abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops have op[0]==0; magnitudes of unsigned operands are the raw values.
  assign in_div    = bus.op[1];
  assign in_sign_a = ~bus.op[0] & bus.a[WIDTH-1];
  assign in_sign_b = ~bus.op[0] & bus.b[WIDTH-1];
  assign in_abs_a  = in_sign_a ? -bus.a : bus.a;
  assign in_abs_b  = in_sign_b ? -bus.b : bus.b;

  assign is_div = (op_reg == MDU_DIV) || (op_reg == MDU_DIVU);
  assign neg    = sign_a_reg ^ sign_b_reg;

  // Multiply: acc low half holds the remaining multiplier bits, opnd the multiplicand.
  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});

  // Divide: acc low half shifts dividend bits out and quotient bits in.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (rem_reg),
    .dividend_bit (acc_reg[WIDTH-1]),
    .divisor      (opnd_reg),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  assign prod_fix = neg ? -acc_reg : acc_reg;
  assign quo_fix  = neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = sign_a_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_next       = op_reg;
    sign_a_next   = sign_a_reg;
    sign_b_next   = sign_b_reg;
    opnd_next     = opnd_reg;
    acc_next      = acc_reg;
    rem_next      = rem_reg;
    div_zero_next = div_zero_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          op_next       = mdu_op_e'(bus.op);
          sign_a_next   = in_sign_a;
          sign_b_next   = in_sign_b;
          count_next    = '0;
          rem_next      = '0;
          div_zero_next = 1'b0;
          if (in_div) begin
            opnd_next = in_abs_b;
            acc_next  = {{WIDTH{1'b0}}, in_abs_a};
          end else begin
            opnd_next = in_abs_a;
            acc_next  = {{WIDTH{1'b0}}, in_abs_b};
          end
          if (in_div && (bus.b == '0)) begin
            div_zero_next = 1'b1;
            state_next    = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        count_next = count_reg + 1'b1;
        if (is_div) begin
          rem_next = step_rem;
          acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], step_q};
        end else begin
          acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
        if (count_reg == LAST) state_next = FIX;
      end
      FIX: begin
        if (is_div) begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end else begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      op_reg       <= MDU_MULT;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      op_reg       <= op_next;
      sign_a_reg   <= sign_a_next;
      sign_b_reg   <= sign_b_next;
      opnd_reg     <= opnd_next;
      acc_reg      <= acc_next;
      rem_reg      <= rem_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit instance for the main scenarios
// and an 8-bit instance for the narrow-width divide.
module tb_mult_div_unit;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus32 ();
  mult_div_unit_if #(.WIDTH(8))  bus8 ();

  mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  function automatic exp_t model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_v, q, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.hi = model_hi; e.lo = model_lo; e.dz = 1'b0; e.lat = 34;
    case (op)
      2'b00: begin p = 64'(sa * sb_v); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin e.dz = 1'b1; e.lat = 1; end
        else begin
          q = sa / sb_v; r = sa % sb_v;
          p = 64'(q); e.lo = p[31:0];
          p = 64'(r); e.hi = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin e.dz = 1'b1; e.lat = 1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push);
    if (push) begin
      sb.push_back(e);
      if (!e.dz) begin model_hi = e.hi; model_lo = e.lo; end
    end
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus32.op = 2'($urandom); bus32.a = $urandom; bus32.b = $urandom;
  endtask

  task automatic wait_done32(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus32.busy) busy_n++;
      if (bus32.done) begin seen = 1'b1; lat = k + 1; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({bus32.busy, bus32.done, bus32.div_zero} !== 3'b000 || bus32.hi !== 32'd0 || bus32.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset32: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero",
               bus32.busy, bus32.done, bus32.div_zero, bus32.hi, bus32.lo);
    end
    n_tests++;
    if ({bus8.busy, bus8.done, bus8.div_zero} !== 3'b000 || bus8.hi !== 8'd0 || bus8.lo !== 8'd0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero",
               bus8.busy, bus8.done, bus8.div_zero, bus8.hi, bus8.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scoreboard();
    logic [1:0]  t_op[8];
    logic [31:0] t_a[8], t_b[8], t_hi[8], t_lo[8];
    exp_t        e, got;
    int          lat, bn, nr;
    bit          seen;
    logic [1:0]  op;
    logic [31:0] a, b;
    t_op = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULT, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU};
    t_a  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
             32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7};
    t_b  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
             32'hFFFFFFFE, 32'h10, 32'd2, 32'd2};
    t_hi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'h40000000,
             32'd1, 32'hF, 32'hFFFFFFFF, 32'd1};
    t_lo = '{32'hFFFFFFEB, 32'h00000001, 32'd1, 32'd0,
             32'hFFFFFFFD, 32'h0FFFFFFF, 32'hFFFFFFFD, 32'd3};
    nr = 6;
    for (int i = 0; i < nr + 8; i++) begin
      if (i < nr) begin
        op = 2'($urandom);
        a  = $urandom;
        b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
        e  = model32(op, a, b);
      end else begin
        op = t_op[i-nr]; a = t_a[i-nr]; b = t_b[i-nr];
        e  = '{hi: t_hi[i-nr], lo: t_lo[i-nr], dz: 1'b0, lat: 34};
      end
      issue32(op, a, b, e, 1'b1);
      wait_done32(lat, bn, seen);
      got = sb.pop_front();
      $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d",
               op, a, b, bus32.hi, bus32.lo, bus32.div_zero, lat, bn);
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL done_timeout[%0d]: no done within bound", i); end
      n_tests++;
      if (bus32.hi !== got.hi || bus32.lo !== got.lo) begin
        n_fail++;
        $display("FAIL hilo[%0d]: got %h_%h expected %h_%h", i, bus32.hi, bus32.lo, got.hi, got.lo);
      end
      n_tests++;
      if (bus32.div_zero !== got.dz) begin
        n_fail++; $display("FAIL div_zero[%0d]: got %b expected %b", i, bus32.div_zero, got.dz);
      end
      n_tests++;
      if (lat != got.lat || bn != got.lat) begin
        n_fail++; $display("FAIL latency[%0d]: got done@%0d busy=%0d expected %0d", i, lat, bn, got.lat);
      end
      @(negedge clk);
      n_tests++;
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
        n_fail++; $display("FAIL pulse[%0d]: got done=%b busy=%b expected 0 0", i, bus32.done, bus32.busy);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e, got;
    int   lat, bn;
    bit   seen;
    e = '{hi: model_hi, lo: model_lo, dz: 1'b1, lat: 1};
    issue32(MDU_DIV, 32'd1234, 32'd0, e, 1'b1);
    wait_done32(lat, bn, seen);
    got = sb.pop_front();
    $display("[TB] DIV by zero -> hi=%h lo=%h dz=%b lat=%0d", bus32.hi, bus32.lo, bus32.div_zero, lat);
    n_tests++;
    if (!seen || lat != got.lat || bn != 1) begin
      n_fail++; $display("FAIL dz_latency: got seen=%b lat=%0d busy=%0d expected 1 1 1", seen, lat, bn);
    end
    n_tests++;
    if (bus32.div_zero !== 1'b1 || bus32.hi !== got.hi || bus32.lo !== got.lo) begin
      n_fail++;
      $display("FAIL dz_flag: got dz=%b hi=%h lo=%h expected 1 %h %h", bus32.div_zero, bus32.hi, bus32.lo, got.hi, got.lo);
    end
    e = '{hi: 32'd0, lo: 32'd15, dz: 1'b0, lat: 34};
    issue32(MDU_MULTU, 32'd3, 32'd5, e, 1'b1);
    n_tests++;
    if (bus32.div_zero !== 1'b0) begin
      n_fail++; $display("FAIL dz_clear: got %b expected 0 after accepted start", bus32.div_zero);
    end
    wait_done32(lat, bn, seen);
    got = sb.pop_front();
    $display("[TB] MULTU 3*5 -> hi=%h lo=%h dz=%b lat=%0d", bus32.hi, bus32.lo, bus32.div_zero, lat);
    n_tests++;
    if (!seen || bus32.lo !== got.lo || bus32.hi !== got.hi || bus32.div_zero !== 1'b0) begin
      n_fail++; $display("FAIL dz_next_op: got hi=%h lo=%h dz=%b expected %h %h 0", bus32.hi, bus32.lo, bus32.div_zero, got.hi, got.lo);
    end
  endtask

  task automatic test_ignored_start();
    exp_t        e, got;
    int          dones, first;
    logic [31:0] cap_hi, cap_lo;
    e = '{hi: 32'd0, lo: 32'h80000000, dz: 1'b0, lat: 34};
    issue32(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, e, 1'b1);
    dones = 0; first = 0; cap_hi = 'x; cap_lo = 'x;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus32.start = 1'b1; bus32.op = MDU_MULTU; bus32.a = $urandom; bus32.b = $urandom;
      end else begin
        bus32.start = 1'b0;
      end
      if (bus32.done) begin
        dones++;
        if (first == 0) begin first = k + 1; cap_hi = bus32.hi; cap_lo = bus32.lo; end
      end
    end
    got = sb.pop_front();
    $display("[TB] DIV MIN/-1 with stray start -> hi=%h lo=%h dones=%0d lat=%0d", cap_hi, cap_lo, dones, first);
    n_tests++;
    if (dones != 1 || first != got.lat) begin
      n_fail++; $display("FAIL busy_start: got dones=%0d lat=%0d expected 1 %0d", dones, first, got.lat);
    end
    n_tests++;
    if (cap_hi !== got.hi || cap_lo !== got.lo) begin
      n_fail++; $display("FAIL min_div: got %h_%h expected %h_%h", cap_hi, cap_lo, got.hi, got.lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int   lat, bn;
    bit   seen;
    e = '{hi: 32'd0, lo: 32'd42, dz: 1'b0, lat: 34};
    issue32(MDU_MULTU, 32'd6, 32'd7, e, 1'b1);
    wait_done32(lat, bn, seen);
    got = sb.pop_front();
    // start presented in the DONE cycle must not launch an op
    bus32.start = 1'b1; bus32.op = MDU_MULTU; bus32.a = 32'd2; bus32.b = 32'd3;
    $display("[TB] MULTU 6*7 -> lo=%h lat=%0d", bus32.lo, lat);
    n_tests++;
    if (!seen || bus32.lo !== got.lo || bus32.hi !== got.hi) begin
      n_fail++; $display("FAIL b2b_first: got %h_%h expected %h_%h", bus32.hi, bus32.lo, got.hi, got.lo);
    end
    @(negedge clk);
    bus32.start = 1'b0;
    n_tests++;
    if (bus32.busy !== 1'b0) begin
      n_fail++; $display("FAIL done_start: got busy=%b expected 0", bus32.busy);
    end
    e = '{hi: 32'd0, lo: 32'd81, dz: 1'b0, lat: 34};
    issue32(MDU_MULT, 32'd9, 32'd9, e, 1'b1);
    wait_done32(lat, bn, seen);
    got = sb.pop_front();
    $display("[TB] MULT 9*9 -> lo=%h lat=%0d", bus32.lo, lat);
    n_tests++;
    if (!seen || bus32.lo !== got.lo || bus32.hi !== got.hi || lat != got.lat) begin
      n_fail++; $display("FAIL b2b_second: got %h_%h lat=%0d expected %h_%h lat=%0d",
                         bus32.hi, bus32.lo, lat, got.hi, got.lo, got.lat);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   stray;
    e = '{hi: 32'd0, lo: 32'd0, dz: 1'b0, lat: 34};
    issue32(MDU_MULT, 32'h12345678, 32'h9ABCDEF0, e, 1'b0);
    repeat (10) @(negedge clk);
    n_tests++;
    if (bus32.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy: got busy=%b expected 1 before reset", bus32.busy);
    end
    reset = 1'b0;
    #1;
    $display("[TB] reset mid-MULT -> busy=%b hi=%h lo=%h", bus32.busy, bus32.hi, bus32.lo);
    n_tests++;
    if ({bus32.busy, bus32.done, bus32.div_zero} !== 3'b000 || bus32.hi !== 32'd0 || bus32.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
               bus32.busy, bus32.done, bus32.div_zero, bus32.hi, bus32.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    model_hi = '0; model_lo = '0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.busy || bus32.done || bus32.hi != 0 || bus32.lo != 0) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d active cycles after reset expected 0", stray);
    end
  endtask

  task automatic test_width8();
    exp_t e, got;
    int   lat;
    bit   seen;
    e = '{hi: 32'd4, lo: 32'd28, dz: 1'b0, lat: 10};
    sb.push_back(e);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = MDU_DIVU; bus8.a = 8'd200; bus8.b = 8'd7;
    @(posedge clk);
    #1;
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus8.done) begin seen = 1'b1; lat = k + 1; end
    end
    got = sb.pop_front();
    $display("[TB] W8 DIVU 200/7 -> hi=%0d lo=%0d lat=%0d", bus8.hi, bus8.lo, lat);
    n_tests++;
    if (!seen || lat != got.lat) begin
      n_fail++; $display("FAIL w8_latency: got seen=%b lat=%0d expected %0d", seen, lat, got.lat);
    end
    n_tests++;
    if (bus8.hi !== got.hi[7:0] || bus8.lo !== got.lo[7:0] || bus8.div_zero !== got.dz) begin
      n_fail++; $display("FAIL w8_result: got hi=%0d lo=%0d dz=%b expected %0d %0d %b",
                         bus8.hi, bus8.lo, bus8.div_zero, got.hi, got.lo, got.dz);
    end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
    test_reset();
    test_scoreboard();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
